// File: rtl/axi4lite_mst_pkg.sv
// Shared definitions for the single-outstanding AXI4-Lite master.
package axi4lite_mst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD      = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axi4lite_mst.sv
// Single-outstanding AXI4-Lite master: turns a request/response port into
// AXI4-Lite reads and writes, with a per-transaction timeout.
module axi4lite_mst
    import axi4lite_mst_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  m_axi_clk,
    input  logic                  m_axi_resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  rsp_valid,
    output logic                  rsp_wr,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    // Counter wide enough to hold TIMEOUT_CYCLES; a zero limit disables expiry.
    localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
    logic [31:0]             wdata_nxt;
    logic [3:0]              wstrb_nxt;
    logic                    wr, wr_nxt;
    logic                    aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic                    awvalid_nxt, wvalid_nxt, arvalid_nxt, bready_nxt, rready_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt, cnt_inc;
    logic                    req_ready_nxt, rsp_valid_nxt, rsp_wr_nxt, rsp_timeout_nxt;
    logic [31:0]             rsp_rdata_nxt;
    logic [1:0]              rsp_resp_nxt;
    logic                    accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, completing, in_txn;

    assign accept  = req_valid && req_ready;
    assign aw_hs   = m_axi_awvalid && m_axi_awready;
    assign w_hs    = m_axi_wvalid && m_axi_wready;
    assign ar_hs   = m_axi_arvalid && m_axi_arready;
    assign b_hs    = m_axi_bvalid && m_axi_bready;
    assign r_hs    = m_axi_rvalid && m_axi_rready;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign in_txn  = (state == ST_WR) || (state == ST_WR_RESP) ||
                     (state == ST_RD) || (state == ST_RD_RESP);
    // A B/R handshake on the expiry cycle wins over the timeout.
    assign completing = ((state == ST_WR_RESP) && b_hs) || ((state == ST_RD_RESP) && r_hs);

    assign m_axi_awaddr = addr;
    assign m_axi_araddr = addr;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // Next-state and next-output logic; every valid only falls after its own handshake.
    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr;
        wdata_nxt       = m_axi_wdata;
        wstrb_nxt       = m_axi_wstrb;
        wr_nxt          = wr;
        aw_done_nxt     = aw_done || aw_hs;
        w_done_nxt      = w_done || w_hs;
        awvalid_nxt     = m_axi_awvalid && !m_axi_awready;
        wvalid_nxt      = m_axi_wvalid && !m_axi_wready;
        arvalid_nxt     = m_axi_arvalid && !m_axi_arready;
        bready_nxt      = m_axi_bready;
        rready_nxt      = m_axi_rready;
        cnt_nxt         = cnt;
        rsp_valid_nxt   = 1'b0;
        rsp_wr_nxt      = rsp_wr;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_resp_nxt    = rsp_resp;
        rsp_timeout_nxt = rsp_timeout;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    addr_nxt    = req_addr;
                    wdata_nxt   = req_wdata;
                    wstrb_nxt   = req_wstrb;
                    wr_nxt      = req_wr;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    cnt_nxt     = '0;
                    if (req_wr) begin
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = ST_WR;
                    end else begin
                        arvalid_nxt = 1'b1;
                        state_nxt   = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (aw_done_nxt && w_done_nxt) begin
                    bready_nxt = 1'b1;
                    state_nxt  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    bready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_wr_nxt      = 1'b1;
                    rsp_rdata_nxt   = 32'h0;
                    rsp_resp_nxt    = m_axi_bresp;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = ST_IDLE;
                end
            end
            ST_RD: begin
                if (ar_hs) begin
                    rready_nxt = 1'b1;
                    state_nxt  = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (r_hs) begin
                    rready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_wr_nxt      = 1'b0;
                    rsp_rdata_nxt   = m_axi_rdata;
                    rsp_resp_nxt    = m_axi_rresp;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Swallow the late response silently, then go idle.
                if (wr ? b_hs : r_hs) begin
                    bready_nxt = 1'b0;
                    rready_nxt = 1'b0;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (in_txn) begin
            cnt_nxt = cnt_inc;
            if (TIMEOUT_EN && (cnt_inc == CNT_LIMIT) && !completing) begin
                rsp_valid_nxt   = 1'b1;
                rsp_wr_nxt      = wr;
                rsp_rdata_nxt   = 32'h0;
                rsp_resp_nxt    = RESP_SLVERR;
                rsp_timeout_nxt = 1'b1;
                bready_nxt      = wr;
                rready_nxt      = !wr;
                state_nxt       = ST_DRAIN;
            end
        end

        req_ready_nxt = (state_nxt == ST_IDLE);
    end

    // State and registered-output update; reset forces every output to idle values.
    always_ff @(posedge m_axi_clk or negedge m_axi_resetn) begin
        if (!m_axi_resetn) begin
            state         <= ST_IDLE;
            addr          <= '0;
            m_axi_wdata   <= 32'h0;
            m_axi_wstrb   <= 4'h0;
            wr            <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_rready  <= 1'b0;
            cnt           <= '0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_wr        <= 1'b0;
            rsp_rdata     <= 32'h0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
        end else begin
            state         <= state_nxt;
            addr          <= addr_nxt;
            m_axi_wdata   <= wdata_nxt;
            m_axi_wstrb   <= wstrb_nxt;
            wr            <= wr_nxt;
            aw_done       <= aw_done_nxt;
            w_done        <= w_done_nxt;
            m_axi_awvalid <= awvalid_nxt;
            m_axi_wvalid  <= wvalid_nxt;
            m_axi_arvalid <= arvalid_nxt;
            m_axi_bready  <= bready_nxt;
            m_axi_rready  <= rready_nxt;
            cnt           <= cnt_nxt;
            req_ready     <= req_ready_nxt;
            rsp_valid     <= rsp_valid_nxt;
            rsp_wr        <= rsp_wr_nxt;
            rsp_rdata     <= rsp_rdata_nxt;
            rsp_resp      <= rsp_resp_nxt;
            rsp_timeout   <= rsp_timeout_nxt;
        end
    end

endmodule
